mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared memory bus: a data port and an instruction
// fetch port. Data wins ties unless a waiting fetch has been passed over too often.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    input  logic        flush,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        if_ack,
    output logic        mem_ack,
    output logic [31:0] if_rdata,
    output logic [31:0] mem_rdata,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state_reg, state_next;
    logic [2:0]  starve_cnt_reg, starve_cnt_next;
    logic        discard_reg, discard_next;
    logic        armed_reg;
    logic        bus_req_reg, bus_req_next;
    logic        bus_we_reg, bus_we_next;
    logic [31:0] bus_addr_reg, bus_addr_next;
    logic [31:0] bus_wdata_reg, bus_wdata_next;
    logic [3:0]  bus_sel_reg, bus_sel_next;

    // armed_reg holds off arbitration for the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 3'd0;
            discard_reg    <= 1'b0;
            armed_reg      <= 1'b0;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_addr_reg   <= 32'd0;
            bus_wdata_reg  <= 32'd0;
            bus_sel_reg    <= 4'd0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            discard_reg    <= discard_next;
            armed_reg      <= 1'b1;
            bus_req_reg    <= bus_req_next;
            bus_we_reg     <= bus_we_next;
            bus_addr_reg   <= bus_addr_next;
            bus_wdata_reg  <= bus_wdata_next;
            bus_sel_reg    <= bus_sel_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        discard_next    = discard_reg;
        bus_req_next    = bus_req_reg;
        bus_we_next     = bus_we_reg;
        bus_addr_next   = bus_addr_reg;
        bus_wdata_next  = bus_wdata_reg;
        bus_sel_next    = bus_sel_reg;
        case (state_reg)
            IDLE: begin
                if (armed_reg && if_req && (!mem_req || starve_cnt_reg == STARVE_LIM)) begin
                    state_next      = BUSY_IF;
                    starve_cnt_next = 3'd0;
                    bus_req_next    = 1'b1;
                    bus_we_next     = 1'b0;
                    bus_addr_next   = if_addr;
                    bus_wdata_next  = 32'd0;
                    bus_sel_next    = 4'b1111;
                end else if (armed_reg && mem_req) begin
                    state_next     = BUSY_MEM;
                    bus_req_next   = 1'b1;
                    bus_we_next    = mem_we;
                    bus_addr_next  = mem_addr;
                    bus_wdata_next = mem_wdata;
                    bus_sel_next   = mem_sel;
                    // Only grants that actually made a fetch wait count toward starvation.
                    if (if_req && starve_cnt_reg != STARVE_LIM)
                        starve_cnt_next = starve_cnt_reg + 3'd1;
                end
            end
            BUSY_IF: begin
                if (flush)
                    discard_next = 1'b1;
                if (bus_ack) begin
                    state_next   = IDLE;
                    bus_req_next = 1'b0;
                    discard_next = 1'b0;
                end
            end
            BUSY_MEM: begin
                if (bus_ack) begin
                    state_next   = IDLE;
                    bus_req_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_sel   = bus_sel_reg;

    // A flush arriving in the completion cycle itself must also drop the fetch result.
    assign if_ack    = (state_reg == BUSY_IF) && bus_ack && !discard_reg && !flush;
    assign mem_ack   = (state_reg == BUSY_MEM) && bus_ack;
    assign if_rdata  = bus_rdata;
    assign mem_rdata = bus_rdata;
    assign stallreq  = (if_req && !if_ack) || (mem_req && !mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: requester agents, a bus slave,
// and a negedge monitor that checks against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, flush, bus_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic        bus_req, bus_we, if_ack, mem_ack, stallreq;
    logic [31:0] bus_addr, bus_wdata, if_rdata, mem_rdata;
    logic [3:0]  bus_sel;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .flush(flush), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .if_ack(if_ack), .mem_ack(mem_ack),
        .if_rdata(if_rdata), .mem_rdata(mem_rdata),
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_if;
        logic        flushed;
        logic [68:0] fields;   // {we, addr, wdata, sel}
    } exp_t;

    exp_t exp_q[$];
    bit   grant_log[$];        // 1 = fetch grant, 0 = data grant
    int   checks = 0;
    int   errors = 0;
    int   slave_delay = -1;    // -1 = random completion delay
    bit   agents_done = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int limit);
        checks++;
        errors++;
        $display("FAIL %s: no response within %0d cycles at %0t", name, limit, $time);
    endtask

    task automatic wait_ack(input bit is_if, input int limit, input string name);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (is_if ? if_ack : mem_ack) return;
        end
        timeout(name, limit);
    endtask

    task automatic wait_bus_req(input int limit, input string name);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (bus_req) return;
        end
        timeout(name, limit);
    endtask

    // Bus slave: completes each presented request after a short delay.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst && bus_req) begin
                int d;
                d = (slave_delay < 0) ? int'($urandom_range(0, 3)) : slave_delay;
                repeat (d) @(posedge clk);
                @(posedge clk); #1;
                bus_ack   = 1'b1;
                bus_rdata = $urandom();
                @(posedge clk); #1;
                bus_ack   = 1'b0;
            end
        end
    end

    // Monitor / scoreboard with a transaction-level arbitration model.
    logic prev_if_req = 0, prev_mem_req = 0, prev_bus_req = 0, prev_bus_ack = 0;
    int   starve_m = 0;
    int   post_rst = 2;
    initial begin
        forever begin
            exp_t e;
            logic exp_if, exp_mem, win_if;
            @(negedge clk);
            if (!rst) begin
                chk("reset_bus_outputs", 72'({bus_req, bus_we, bus_addr, bus_wdata, bus_sel}), 72'(0));
                chk("reset_acks", 72'({if_ack, mem_ack}), 72'(0));
                exp_q.delete();
                starve_m     = 0;
                post_rst     = 2;
                prev_if_req  = 0;
                prev_mem_req = 0;
                prev_bus_req = 0;
                prev_bus_ack = 0;
            end else begin
                exp_if  = 1'b0;
                exp_mem = 1'b0;
                if (bus_req && !prev_bus_req) begin
                    if (!prev_if_req && !prev_mem_req) begin
                        chk("grant_without_request", 72'(bus_req), 72'(0));
                    end else begin
                        win_if = prev_if_req && (!prev_mem_req || starve_m == STARVE_MAX);
                        if (win_if) starve_m = 0;
                        else if (prev_if_req && starve_m < STARVE_MAX) starve_m++;
                        e.is_if   = win_if;
                        e.flushed = 1'b0;
                        e.fields  = win_if ? {1'b0, if_addr, 32'd0, 4'hF}
                                           : {mem_we, mem_addr, mem_wdata, mem_sel};
                        exp_q.push_back(e);
                        grant_log.push_back(win_if);
                    end
                end
                if (bus_req && exp_q.size() > 0) begin
                    e = exp_q[0];
                    chk("bus_fields", 72'({bus_we, bus_addr, bus_wdata, bus_sel}), 72'(e.fields));
                    if (e.is_if && flush) begin
                        e.flushed = 1'b1;
                        exp_q[0]  = e;
                    end
                end
                if (bus_ack && bus_req && exp_q.size() > 0) begin
                    e       = exp_q.pop_front();
                    exp_if  = e.is_if && !e.flushed;
                    exp_mem = !e.is_if;
                    chk("acks", 72'({if_ack, mem_ack}), 72'({exp_if, exp_mem}));
                    if (exp_if)  chk("if_rdata", 72'(if_rdata), 72'(bus_rdata));
                    if (exp_mem) chk("mem_rdata", 72'(mem_rdata), 72'(bus_rdata));
                end else if (bus_ack) begin
                    chk("ack_while_idle", 72'({if_ack, mem_ack}), 72'(0));
                end
                chk("stallreq", 72'(stallreq), 72'((if_req && !exp_if) || (mem_req && !exp_mem)));
                if (post_rst > 0) post_rst--;
                else if (!prev_bus_req && (prev_if_req || prev_mem_req))
                    chk("grant_after_one_idle", 72'(bus_req), 72'(1));
                if (prev_bus_req && prev_bus_ack)
                    chk("idle_bubble", 72'(bus_req), 72'(0));
                prev_if_req  = if_req;
                prev_mem_req = mem_req;
                prev_bus_req = bus_req;
                prev_bus_ack = bus_ack;
            end
        end
    end

    task automatic if_agent(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if_addr = $urandom() & 32'hFFFF_FFFC;
            if_req  = 1'b1;
            wait_ack(1'b1, 2000, "rand_if_ack");
            @(posedge clk); #1;
            if_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic mem_agent(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_we    = 1'($urandom());
            mem_addr  = $urandom();
            mem_wdata = $urandom();
            mem_sel   = 4'($urandom());
            mem_req   = 1'b1;
            wait_ack(1'b0, 2000, "rand_mem_ack");
            @(posedge clk); #1;
            mem_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic flush_agent();
        while (!agents_done) begin
            @(posedge clk); #1;
            flush = ($urandom_range(0, 7) == 0);
        end
        flush = 1'b0;
    endtask

    initial begin
        int g0;
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; flush = 1'b0;
        if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_sel = 4'd0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;

        fork
            begin
                fork
                    if_agent(40);
                    mem_agent(40);
                join
                agents_done = 1;
            end
            flush_agent();
        join
        repeat (4) @(posedge clk);

        // Single fetch with a fixed three-cycle completion.
        slave_delay = 2;
        @(posedge clk); #1;
        if_addr = 32'h0000_0100;
        if_req  = 1'b1;
        wait_bus_req(10, "fetch_grant");
        chk("fetch_bus_addr_we", 72'({bus_we, bus_addr}), 72'({1'b0, 32'h0000_0100}));
        wait_ack(1'b1, 10, "fetch_ack");
        @(posedge clk); #1;
        if_req = 1'b0;
        repeat (2) @(posedge clk);

        // Contested write: data wins first, fetch follows after one idle cycle.
        @(posedge clk); #1;
        mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF;
        mem_req = 1'b1; if_addr = 32'h0000_0104; if_req = 1'b1;
        wait_bus_req(10, "contested_grant");
        chk("contested_mem_first", 72'({bus_we, bus_addr, bus_wdata}), 72'({1'b1, 32'h80, 32'hDEAD_BEEF}));
        wait_ack(1'b0, 10, "contested_mem_ack");
        @(posedge clk); #1;
        mem_req = 1'b0;
        wait_ack(1'b1, 20, "contested_if_ack");
        @(posedge clk); #1;
        if_req = 1'b0;
        repeat (2) @(posedge clk);

        // Reset in the middle of a data access; the held request is re-granted.
        slave_delay = 3;
        @(posedge clk); #1;
        mem_addr = 32'h0000_0080; mem_req = 1'b1;
        wait_bus_req(10, "pre_reset_grant");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset_drops_bus_req", 72'(bus_req), 72'(0));
        chk("reset_no_mem_ack", 72'(mem_ack), 72'(0));
        repeat (6) @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("no_grant_first_edge", 72'(bus_req), 72'(0));
        wait_bus_req(4, "regrant_after_reset");
        chk("regrant_addr", 72'(bus_addr), 72'(32'h0000_0080));
        wait_ack(1'b0, 10, "regrant_mem_ack");
        @(posedge clk); #1;
        mem_req = 1'b0;
        repeat (2) @(posedge clk);

        // Starvation: continuous data traffic yields to the fetch after STARVE_MAX grants.
        slave_delay = -1;
        g0 = grant_log.size();
        @(posedge clk); #1;
        mem_we = 1'b0; mem_addr = 32'h0000_1000; mem_req = 1'b1;
        if_addr = 32'h0000_0200; if_req = 1'b1;
        wait_ack(1'b1, 200, "starve_if_ack");
        @(posedge clk); #1;
        if_req = 1'b0;
        chk("starve_grant_count", 72'(grant_log.size() >= g0 + STARVE_MAX + 1), 72'(1));
        if (grant_log.size() >= g0 + STARVE_MAX + 1)
            for (int k = 0; k <= STARVE_MAX; k++)
                chk($sformatf("starve_grant_%0d", k), 72'(grant_log[g0 + k]), 72'(k == STARVE_MAX));
        wait_ack(1'b0, 20, "starve_tail_mem_ack");
        @(posedge clk); #1;
        mem_req = 1'b0;
        repeat (2) @(posedge clk);

        // Flush during a fetch: result dropped, re-issued fetch served normally.
        slave_delay = 2;
        @(posedge clk); #1;
        if_addr = 32'h0000_0300; if_req = 1'b1;
        wait_bus_req(10, "flush_fetch_grant");
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk);
                if (bus_ack) begin
                    seen = 1;
                    chk("flushed_if_ack", 72'(if_ack), 72'(0));
                end
            end
            if (!seen) timeout("flush_bus_ack", 10);
        end
        @(negedge clk);
        chk("flush_back_to_idle", 72'(bus_req), 72'(0));
        wait_ack(1'b1, 20, "refetch_ack");
        @(posedge clk); #1;
        if_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
